// File: rtl/rot_sweep_ctrl.sv
// rot_sweep_ctrl: command sequencer wrapped around an external combinational rotator.
// One command (word, direction, step, length) is swept through rotate amounts
// 0, step, 2*step, ... (mod BIT). Each rotator result is registered and emitted as one
// beat of a valid/ready output stream.
// Optional build macro ROT_SWEEP_CNT_EN adds o_cmd_cnt, a saturating count of
// completed commands (handshakes of beats carrying o_last).
module rot_sweep_ctrl #(
    parameter int unsigned BIT = 8,
    parameter int unsigned AW  = $clog2(BIT)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [BIT-1:0] i_data,
    input  logic           i_left,
    input  logic [AW-1:0]  i_step,
    input  logic [AW-1:0]  i_len,
    output logic [BIT-1:0] o_rot_data,
    output logic           o_rot_left,
    output logic [AW-1:0]  o_rot_amt,
    input  logic [BIT-1:0] i_rot_result,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [BIT-1:0] o_data,
    output logic [AW-1:0]  o_amt,
    output logic           o_last,
`ifdef ROT_SWEEP_CNT_EN
    output logic [15:0]    o_cmd_cnt,
`endif
    output logic           o_busy
);

    typedef enum logic {StIdle, StRun} state_t;

    state_t         state;
    logic [BIT-1:0] cmd_data;
    logic           cmd_left;
    logic [AW-1:0]  cmd_step;
    logic [AW-1:0]  cmd_len;
    logic [AW-1:0]  amt;
    logic [AW-1:0]  idx;
    logic           load;

    // Rotator is driven straight from the command registers and the running amount.
    always_comb begin
        o_rot_data = cmd_data;
        o_rot_left = cmd_left;
        o_rot_amt  = amt;
        o_ready    = (state == StIdle);
        o_busy     = (state == StRun);
        load       = (state == StRun) && (!o_valid || i_ready);
    end

    // Sweep FSM plus output register; a load in the same cycle as a handshake replaces the beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= StIdle;
            cmd_data <= '0;
            cmd_left <= 1'b0;
            cmd_step <= '0;
            cmd_len  <= '0;
            amt      <= '0;
            idx      <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_amt    <= '0;
            o_last   <= 1'b0;
        end else begin
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
            unique case (state)
                StIdle: begin
                    if (i_valid) begin
                        cmd_data <= i_data;
                        cmd_left <= i_left;
                        cmd_step <= i_step;
                        cmd_len  <= i_len;
                        amt      <= '0;
                        idx      <= '0;
                        state    <= StRun;
                    end
                end
                StRun: begin
                    if (load) begin
                        o_data  <= i_rot_result;
                        o_amt   <= amt;
                        o_last  <= (idx == cmd_len);
                        o_valid <= 1'b1;
                        // Natural AW-bit wrap gives the modulo-BIT amount.
                        amt     <= amt + cmd_step;
                        idx     <= idx + 1'b1;
                        if (idx == cmd_len) begin
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

`ifdef ROT_SWEEP_CNT_EN
    // Saturating count of completed commands.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_cmd_cnt <= '0;
        end else if (o_valid && i_ready && o_last && (o_cmd_cnt != 16'hFFFF)) begin
            o_cmd_cnt <= o_cmd_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rot_sweep_ctrl.sv
// Testbench for rot_sweep_ctrl: directed scenarios plus randomized commands with random
// backpressure, checked against a beat-list model built from the sweep rules.
module tb_rot_sweep_ctrl;

    localparam int BIT = 8;
    localparam int AW  = $clog2(BIT);

    logic           clk = 1'b0;
    logic           i_rst;
    logic           i_valid;
    logic           o_ready;
    logic [BIT-1:0] i_data;
    logic           i_left;
    logic [AW-1:0]  i_step;
    logic [AW-1:0]  i_len;
    logic [BIT-1:0] o_rot_data;
    logic           o_rot_left;
    logic [AW-1:0]  o_rot_amt;
    logic [BIT-1:0] rot_result;
    logic           o_valid;
    logic           i_ready;
    logic [BIT-1:0] o_data;
    logic [AW-1:0]  o_amt;
    logic           o_last;
    logic           o_busy;
`ifdef ROT_SWEEP_CNT_EN
    logic [15:0]    o_cmd_cnt;
`endif

    always #5 clk = ~clk;

    rot_sweep_ctrl #(.BIT(BIT)) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_data       (i_data),
        .i_left       (i_left),
        .i_step       (i_step),
        .i_len        (i_len),
        .o_rot_data   (o_rot_data),
        .o_rot_left   (o_rot_left),
        .o_rot_amt    (o_rot_amt),
        .i_rot_result (rot_result),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_amt        (o_amt),
        .o_last       (o_last),
`ifdef ROT_SWEEP_CNT_EN
        .o_cmd_cnt    (o_cmd_cnt),
`endif
        .o_busy       (o_busy)
    );

    // Combinational rotator the controller is wrapped around.
    function automatic logic [BIT-1:0] rot_env(logic [BIT-1:0] d, logic [AW-1:0] a, logic left);
        int sh;
        sh = int'(a);
        if (sh == 0) return d;
        if (left) return (d << sh) | (d >> (BIT - sh));
        return (d >> sh) | (d << (BIT - sh));
    endfunction

    assign rot_result = rot_env(o_rot_data, o_rot_amt, o_rot_left);

    typedef struct packed {
        logic [BIT-1:0] data;
        logic [AW-1:0]  amt;
        logic           last;
    } beat_t;

    beat_t exp_q[$];
    int    errors    = 0;
    int    checks    = 0;
    int    cnt_model = 0;

    // Reference rotation: n single-bit rotates.
    function automatic logic [BIT-1:0] ref_rot(logic [BIT-1:0] d, int n, logic left);
        logic [BIT-1:0] r;
        r = d;
        for (int i = 0; i < n; i++) begin
            r = left ? {r[BIT-2:0], r[BIT-1]} : {r[0], r[BIT-1:1]};
        end
        return r;
    endfunction

    task automatic model_cmd(logic [BIT-1:0] d, logic left, int step, int len);
        beat_t b;
        for (int k = 0; k <= len; k++) begin
            int a;
            a      = (k * step) % BIT;
            b.data = ref_rot(d, a, left);
            b.amt  = AW'(a);
            b.last = (k == len);
            exp_q.push_back(b);
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard any handshake at the coming edge, then advance one cycle.
    task automatic tick();
        beat_t b;
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_beat", 32'(exp_q.size()), 32'd1);
            end else begin
                b = exp_q.pop_front();
                chk("beat_data", 32'(o_data), 32'(b.data));
                chk("beat_amt", 32'(o_amt), 32'(b.amt));
                chk("beat_last", 32'(o_last), 32'(b.last));
                if (b.last && cnt_model < 65535) cnt_model++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ready(logic rnd);
        if (rnd) i_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Present a command and hold it until accepted; returns one cycle after the accept edge.
    task automatic send(logic [BIT-1:0] d, logic left, logic [AW-1:0] step, logic [AW-1:0] len,
                        logic rnd);
        int n;
        n       = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_left  = left;
        i_step  = step;
        i_len   = len;
        while (!o_ready && n < 100) begin
            rand_ready(rnd);
            tick();
            n++;
        end
        chk("accept_wait", 32'(n < 100), 32'd1);
        model_cmd(d, left, int'(step), int'(len));
        rand_ready(rnd);
        tick();
        i_valid = 1'b0;
        i_data  = BIT'($urandom);
        i_left  = 1'($urandom);
        i_step  = AW'($urandom);
        i_len   = AW'($urandom);
    endtask

    task automatic drain(logic rnd);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            rand_ready(rnd);
            tick();
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [BIT-1:0] t2_data [4];
        logic [AW-1:0]  t2_amt  [4];
        t2_data = '{8'h01, 8'h20, 8'h04, 8'h80};
        t2_amt  = '{3'd0, 3'd3, 3'd6, 3'd1};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;
        i_left  = 1'b0;
        i_step  = '0;
        i_len   = '0;
        #1;
        tick();
        tick();
        i_rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_amt", 32'(o_amt), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_rot_data", 32'(o_rot_data), 32'd0);
        chk("rst_rot_amt", 32'(o_rot_amt), 32'd0);
        chk("rst_rot_left", 32'(o_rot_left), 32'd0);
`ifdef ROT_SWEEP_CNT_EN
        chk("rst_cnt", 32'(o_cmd_cnt), 32'd0);
`endif

        // Full left sweep, one beat per cycle from N+2
        send(8'h01, 1'b1, 3'd1, 3'd7, 1'b0);
        chk("t1_busy", 32'(o_busy), 32'd1);
        chk("t1_bubble", 32'(o_valid), 32'd0);
        chk("t1_rot_data", 32'(o_rot_data), 32'h01);
        tick();
        chk("t1_first_valid", 32'(o_valid), 32'd1);
        chk("t1_first_data", 32'(o_data), 32'h01);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk("t1_stream_valid", 32'(o_valid), 32'd1);
            chk("t1_stream_data", 32'(o_data), 32'(1 << k));
            chk("t1_stream_ready", 32'(o_ready), 32'(k == 7));
        end
        chk("t1_last", 32'(o_last), 32'd1);
        chk("t1_idle_busy", 32'(o_busy), 32'd0);
        drain(1'b0);
        chk("t1_after_valid", 32'(o_valid), 32'd0);

        // Right rotate with step 3: amounts wrap modulo BIT
        send(8'h01, 1'b0, 3'd3, 3'd3, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t2_data", 32'(o_data), 32'(t2_data[k]));
            chk("t2_amt", 32'(o_amt), 32'(t2_amt[k]));
            tick();
        end
        drain(1'b0);

        // Backpressure after third beat
        send(8'h01, 1'b1, 3'd1, 3'd7, 1'b0);
        tick();
        tick();
        tick();
        i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("t3_hold_data", 32'(o_data), 32'h04);
            chk("t3_hold_valid", 32'(o_valid), 32'd1);
            chk("t3_hold_ready", 32'(o_ready), 32'd0);
            tick();
        end
        chk("t3_hold_amt", 32'(o_amt), 32'd2);
        i_ready = 1'b1;
        drain(1'b0);

        // step=0 then a back-to-back command: one bubble between commands
        send(8'hA5, 1'b1, 3'd0, 3'd2, 1'b0);
        tick();
        chk("t4_b0", 32'(o_data), 32'hA5);
        tick();
        tick();
        chk("t4_idle_at_last", 32'(o_ready), 32'd1);
        chk("t4_last", 32'(o_last), 32'd1);
        send(8'h3C, 1'b0, 3'd2, 3'd1, 1'b0);
        chk("t4_bubble", 32'(o_valid), 32'd0);
        tick();
        chk("t4_second_valid", 32'(o_valid), 32'd1);
        chk("t4_second_amt", 32'(o_amt), 32'd0);
        chk("t4_second_data", 32'(o_data), 32'h3C);
        drain(1'b0);
`ifdef ROT_SWEEP_CNT_EN
        chk("cnt_after_four", 32'(o_cmd_cnt), 32'(cnt_model));
`endif

        // Reset in the middle of a sweep
        send(8'h01, 1'b1, 3'd1, 3'd7, 1'b0);
        tick();
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        exp_q.delete();
        cnt_model = 0;
        chk("t5_valid", 32'(o_valid), 32'd0);
        chk("t5_busy", 32'(o_busy), 32'd0);
        chk("t5_ready", 32'(o_ready), 32'd1);
        chk("t5_rot_amt", 32'(o_rot_amt), 32'd0);
        chk("t5_rot_data", 32'(o_rot_data), 32'd0);
`ifdef ROT_SWEEP_CNT_EN
        chk("t5_cnt", 32'(o_cmd_cnt), 32'd0);
`endif
        send(8'h80, 1'b1, 3'd5, 3'd4, 1'b0);
        tick();
        chk("t5_restart_amt", 32'(o_amt), 32'd0);
        chk("t5_restart_data", 32'(o_data), 32'h80);
        drain(1'b0);
        send(8'h81, 1'b0, 3'd7, 3'd0, 1'b0);
        drain(1'b0);
`ifdef ROT_SWEEP_CNT_EN
        chk("t5_cnt_two", 32'(o_cmd_cnt), 32'd2);
`endif

        // Randomized commands with random backpressure, sometimes back-to-back
        for (int i = 0; i < 40; i++) begin
            send(BIT'($urandom), 1'($urandom), AW'($urandom), AW'($urandom), 1'b1);
            if ($urandom_range(0, 2) == 0) drain(1'b1);
        end
        drain(1'b1);
        i_ready = 1'b1;
        tick();
        chk("final_valid", 32'(o_valid), 32'd0);
        chk("final_ready", 32'(o_ready), 32'd1);
`ifdef ROT_SWEEP_CNT_EN
        chk("final_cnt", 32'(o_cmd_cnt), 32'(cnt_model));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rot_sweep_ctrl.md
# rot_sweep_ctrl

Command sequencer that sits directly in front of the combinational rotator and also consumes its result. It accepts one command (data word, direction, step, length) over a valid/ready handshake. It drives the rotator with the same word at amounts 0, step, 2·step, … (mod BIT). Each rotator result is registered and emitted as one beat of an output stream with backpressure.

## Interface
- BIT, 8, data width; must be a power of two, ≥2
- AW, $clog2(BIT), width of rotate amount, step and length fields
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_valid  in  1  command valid
- o_ready  out  1  command ready; high only in IDLE
- i_data  in  BIT  word to rotate
- i_left  in  1  1 = rotate left, 0 = rotate right
- i_step  in  AW  amount increment per beat
- i_len  in  AW  beats per command minus 1 (1..BIT beats)
- o_rot_data  out  BIT  to rotator data input (latched word)
- o_rot_left  out  1  to rotator direction select
- o_rot_amt  out  AW  to rotator shift amount
- i_rot_result  in  BIT  rotator output; combinational, same cycle
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream ready
- o_data  out  BIT  registered rotated word
- o_amt  out  AW  rotate amount that produced o_data
- o_last  out  1  final beat of command
- o_busy  out  1  state is RUN

## Operation
- States: IDLE, RUN.
- IDLE: o_ready=1. On i_valid&&o_ready:
  - latch i_data, i_left, i_step, i_len into command regs
  - amt=0, idx=0; go to RUN
- RUN: o_ready=0.
  - o_rot_data/o_rot_left/o_rot_amt are driven straight from the command regs and amt.
  - load = RUN && (!o_valid || i_ready).
  - On load:
    - o_data←i_rot_result, o_amt←amt, o_last←(idx==len), o_valid←1
    - amt←(amt+step) mod BIT (natural AW-bit wrap)
    - idx←idx+1
    - if idx==len, go to IDLE
- Output reg: o_valid&&i_ready with no load in the same cycle clears o_valid. A handshake with a simultaneous load replaces the beat (no bubble).
- While o_valid&&!i_ready: o_data, o_amt and o_last hold stable.
- A new command may be accepted while the previous last beat is still pending in the output reg. Its first load waits for that beat to be consumed.
- Boundaries:
  - step=0: all beats equal i_data at amt 0.
  - len=0: single beat with o_last=1.
  - len=BIT-1, step=1: full sweep, amts 0..BIT-1.
  - Amount wraps modulo BIT.
- Reset (any state, including mid-sweep): state=IDLE and o_valid=0. o_data, o_amt, o_last, o_busy, amt, idx and all command regs go to 0, so o_rot_* = 0. The in-flight command is discarded.

## Timing
- Command handshake in cycle N → RUN in N+1 → first o_valid in N+2.
- Steady state with i_ready=1: one beat per cycle. len+1 beats occupy cycles N+2..N+2+len.
- IDLE is re-entered in cycle N+2+len, so the earliest next command accept is that cycle. Its first beat appears at N+4+len (one bubble between commands).
- Rotator path is combinational, regs→rotator→o_data: one cycle.

## Configuration
- ROT_SWEEP_CNT_EN defined:
  - Adds output o_cmd_cnt, 16 bits, reset 0.
  - Increments on each output handshake with o_last=1.
  - Saturates at 0xFFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- BIT=8, i_data=0x01, left, step=1, len=7, i_ready=1 → o_data 0x01,0x02,0x04…0x80 on 8 consecutive cycles starting N+2; o_amt 0..7; o_last only on 0x80.
- i_data=0x01, right, step=3, len=3 → amts 0,3,6,1; o_data 0x01,0x20,0x04,0x80; o_last on 4th beat.
- Same as the first test, but with i_ready low for 3 cycles after the 3rd beat appears → 0x04 held stable for 3 cycles; sequence then resumes 0x08…0x80; no beat lost or duplicated; o_ready=0 throughout.
- i_data=0xA5, step=0, len=2, left → three beats of 0xA5 at amt 0; then a second command issued back-to-back → accepted in the cycle IDLE returns, one-bubble gap.
- i_rst=1 mid-sweep after beat 2 of the first test → next cycle o_valid=0, o_busy=0, o_ready=1, o_rot_amt=0; a fresh command restarts at amt 0.
- With ROT_SWEEP_CNT_EN: two complete commands → o_cmd_cnt=2; command aborted by reset → 0.
